// File: rtl/audio_echo_mix_if.sv
// Codec-side bundle for the echo stage: frame strobe, record samples and controls in,
// play samples and status out.
interface audio_echo_mix_if #(
  parameter int N      = 24,
  parameter int ADDR_W = 10,
  parameter int GAIN_W = 8
);
  logic              NewFrame;
  logic [N-1:0]      LeftRecData;
  logic [N-1:0]      RightRecData;
  logic [ADDR_W-1:0] delay;
  logic [GAIN_W-1:0] gain;
  logic              bypass;
  logic [N-1:0]      LeftPlayData;
  logic [N-1:0]      RightPlayData;
  logic              sample_valid;
  logic              sat_flag;
  logic              busy;
  logic              overrun;

  modport master (
    output NewFrame, LeftRecData, RightRecData, delay, gain, bypass,
    input  LeftPlayData, RightPlayData, sample_valid, sat_flag, busy, overrun
  );

  modport slave (
    input  NewFrame, LeftRecData, RightRecData, delay, gain, bypass,
    output LeftPlayData, RightPlayData, sample_valid, sat_flag, busy, overrun
  );
endinterface

// File: rtl/audio_echo_mix.sv
// Stereo feedback-delay stage: per frame, mix each record sample with a gain-scaled
// delayed sample from a per-channel circular buffer, saturate, and write it back.

// Per-channel mix datapath: in + floor(d * gain / 2^GAIN_W), saturated to N bits.
module audio_echo_mix_lane #(
  parameter int N      = 24,
  parameter int GAIN_W = 8
) (
  input  logic [N-1:0]      in_i,
  input  logic [N-1:0]      d_i,
  input  logic [GAIN_W-1:0] gain_i,
  input  logic              bypass_i,
  input  logic              use_d_i,
  output logic [N-1:0]      res_o,
  output logic              sat_o
);
  localparam int PW = N + GAIN_W + 1;

  logic [N-1:0]  d;
  logic [PW-1:0] d_x, g_x, prod;
  logic [N:0]    scaled, sum;
  logic          ovf;

  always_comb begin
    d      = use_d_i ? d_i : '0;
    d_x    = {{(GAIN_W+1){d[N-1]}}, d};
    g_x    = {{(N+1){1'b0}}, gain_i};
    // Modulo-2^PW product equals the signed product since it fits in PW bits.
    prod   = d_x * g_x;
    // Dropping the low GAIN_W bits is the floor (arithmetic) shift.
    scaled = prod[PW-1:GAIN_W];
    sum    = {in_i[N-1], in_i} + scaled;
    ovf    = sum[N] ^ sum[N-1];
    res_o  = sum[N-1:0];
    sat_o  = 1'b0;
    if (bypass_i) begin
      res_o = in_i;
    end else if (ovf) begin
      res_o = sum[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      sat_o = 1'b1;
    end
  end
endmodule

module audio_echo_mix #(
  parameter int N      = 24,
  parameter int ADDR_W = 10,
  parameter int GAIN_W = 8
) (
  input  logic             audio_clk,
  input  logic             reset,
  audio_echo_mix_if.slave  io
);
  localparam int NCH   = 2;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [3:0] {
    S_CLEAR, S_IDLE, S_RD_L, S_MIX_L, S_WR_L, S_RD_R, S_MIX_R, S_WR_R, S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic                     nf_q, rise;
  logic [NCH-1:0][N-1:0]    in_q, res_q, play_q, mix_res;
  logic [NCH-1:0]           sat_q, mix_sat, we, re, mix_en;
  logic [ADDR_W-1:0]        dly_q, wr_ptr_q, clr_addr_q, addr;
  logic [GAIN_W-1:0]        gain_q;
  logic                     byp_q, valid_q, sat_flag_q, overrun_q;
  logic                     latch_en, out_en, ptr_inc, drop;

  assign rise = io.NewFrame & ~nf_q;

  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    out_en   = 1'b0;
    ptr_inc  = 1'b0;
    drop     = rise && (state_q != S_IDLE);
    unique case (state_q)
      S_CLEAR: if (&clr_addr_q) state_d = S_IDLE;
      S_IDLE:  if (rise) begin
                 state_d  = S_RD_L;
                 latch_en = 1'b1;
               end
      S_RD_L:  state_d = S_MIX_L;
      S_MIX_L: state_d = S_WR_L;
      S_WR_L:  state_d = S_RD_R;
      S_RD_R:  state_d = S_MIX_R;
      S_MIX_R: state_d = S_WR_R;
      S_WR_R:  begin
                 state_d = S_DONE;
                 out_en  = 1'b1;
               end
      S_DONE:  begin
                 state_d = S_IDLE;
                 ptr_inc = 1'b1;
               end
      default: state_d = S_CLEAR;
    endcase
  end

  // One shared address per cycle: clear sweep, delayed read, or write-back at wr_ptr.
  always_comb begin
    if (state_q == S_CLEAR)                          addr = clr_addr_q;
    else if (state_q == S_RD_L || state_q == S_RD_R) addr = wr_ptr_q - dly_q;
    else                                             addr = wr_ptr_q;
    we     = {state_q == S_WR_R, state_q == S_WR_L} | {NCH{state_q == S_CLEAR}};
    re     = {state_q == S_RD_R, state_q == S_RD_L};
    mix_en = {state_q == S_MIX_R, state_q == S_MIX_L};
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [N-1:0] mem [DEPTH];
    logic [N-1:0] rd_q;

    always_ff @(posedge audio_clk) begin
      if (we[g]) mem[addr] <= (state_q == S_CLEAR) ? '0 : res_q[g];
      if (re[g]) rd_q <= mem[addr];
    end

    audio_echo_mix_lane #(.N(N), .GAIN_W(GAIN_W)) u_lane (
      .in_i     (in_q[g]),
      .d_i      (rd_q),
      .gain_i   (gain_q),
      .bypass_i (byp_q),
      .use_d_i  (dly_q != '0),
      .res_o    (mix_res[g]),
      .sat_o    (mix_sat[g])
    );
  end

  always_ff @(posedge audio_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_CLEAR;
      nf_q       <= 1'b0;
      in_q       <= '0;
      res_q      <= '0;
      sat_q      <= '0;
      play_q     <= '0;
      dly_q      <= '0;
      gain_q     <= '0;
      byp_q      <= 1'b0;
      wr_ptr_q   <= '0;
      clr_addr_q <= '0;
      valid_q    <= 1'b0;
      sat_flag_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      nf_q    <= io.NewFrame;
      valid_q <= out_en;
      if (state_q == S_CLEAR) clr_addr_q <= clr_addr_q + ADDR_W'(1);
      if (latch_en) begin
        in_q   <= {io.RightRecData, io.LeftRecData};
        dly_q  <= io.delay;
        gain_q <= io.gain;
        byp_q  <= io.bypass;
      end
      for (int c = 0; c < NCH; c++) begin
        if (mix_en[c]) begin
          res_q[c] <= mix_res[c];
          sat_q[c] <= mix_sat[c];
        end
      end
      if (out_en) begin
        play_q     <= res_q;
        sat_flag_q <= |sat_q;
      end
      if (ptr_inc) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (drop)    overrun_q <= 1'b1;
    end
  end

  assign io.LeftPlayData  = play_q[0];
  assign io.RightPlayData = play_q[1];
  assign io.sample_valid  = valid_q;
  assign io.sat_flag      = sat_flag_q;
  assign io.busy          = (state_q != S_IDLE);
  assign io.overrun       = overrun_q;
endmodule

// File: tb/tb_audio_echo_mix.sv
// Scoreboarded bench for audio_echo_mix: a frame-level echo model predicts each play
// sample and its arrival cycle; a monitor compares whenever sample_valid pulses.
module tb_audio_echo_mix;
  localparam int N = 24, AW = 10, GW = 8, DEPTH = 1 << AW;
  localparam int MAXP = 8388607, MINN = -8388608;

  logic audio_clk = 1'b0;
  logic reset     = 1'b0;
  always #5 audio_clk = ~audio_clk;

  audio_echo_mix_if #(.N(N), .ADDR_W(AW), .GAIN_W(GW)) io ();
  audio_echo_mix #(.N(N), .ADDR_W(AW), .GAIN_W(GW)) dut (
    .audio_clk (audio_clk),
    .reset     (reset),
    .io        (io)
  );

  typedef struct { int l; int r; int sat; int cyc; } exp_t;
  exp_t sbq[$];
  int   obs_l[$], obs_r[$], obs_sat[$];
  int   vecs = 0, errs = 0, cyc = 0;
  int   mem_l[DEPTH], mem_r[DEPTH], wp;

  always @(posedge audio_clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input longint act, input longint exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: actual %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Frame-level reference: floor-scaled echo added to input, clamped to 24-bit range.
  function automatic void ref_mix(input int x, input int d, input int g, output int res, output int s);
    longint sum;
    sum = longint'(x) + ((longint'(d) * longint'(g)) >>> GW);
    s   = 0;
    res = int'(sum);
    if (sum > MAXP)      begin res = MAXP; s = 1; end
    else if (sum < MINN) begin res = MINN; s = 1; end
  endfunction

  always @(negedge audio_clk) begin
    if (reset && io.sample_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_sample_valid", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("left_play",  int'($signed(io.LeftPlayData)),  e.l);
        chk("right_play", int'($signed(io.RightPlayData)), e.r);
        chk("sat_flag",   io.sat_flag, e.sat);
        chk("latency",    cyc, e.cyc);
      end
      obs_l.push_back(int'($signed(io.LeftPlayData)));
      obs_r.push_back(int'($signed(io.RightPlayData)));
      obs_sat.push_back(int'(io.sat_flag));
    end
  end

  // Caller sits on a negedge; reset asserts immediately so it can land mid-sequence.
  task automatic do_reset(input bit inject);
    int n;
    reset       = 1'b0;
    io.NewFrame = 1'b0;
    sbq.delete();
    foreach (mem_l[i]) begin mem_l[i] = 0; mem_r[i] = 0; end
    wp = 0;
    repeat (3) @(negedge audio_clk);
    chk("rst_left",    io.LeftPlayData, 0);
    chk("rst_right",   io.RightPlayData, 0);
    chk("rst_valid",   io.sample_valid, 0);
    chk("rst_sat",     io.sat_flag, 0);
    chk("rst_overrun", io.overrun, 0);
    chk("rst_busy",    io.busy, 1);
    reset = 1'b1;
    n = 0;
    while (1) begin
      @(posedge audio_clk);
      #1;
      n++;
      if (inject && n == 500) io.NewFrame = 1'b1;
      if (inject && n == 502) io.NewFrame = 1'b0;
      if (!io.busy || n >= 2000) break;
    end
    chk("clear_cycles", n, 1024);
    if (inject) chk("clear_drop_overrun", io.overrun, 1);
    @(negedge audio_clk);
  endtask

  // Caller sits on a negedge (cycle c); returns on the negedge of cycle c+1.
  task automatic launch(input logic [N-1:0] l, input logic [N-1:0] r,
                        input int dly, input int g, input bit byp);
    exp_t e;
    int il, ir, dl, dr;
    il = int'($signed(l));
    ir = int'($signed(r));
    if (byp) begin
      e.l = il; e.r = ir; e.sat = 0;
    end else begin
      int sl, sr;
      dl = (dly == 0) ? 0 : mem_l[(wp - dly + DEPTH) % DEPTH];
      dr = (dly == 0) ? 0 : mem_r[(wp - dly + DEPTH) % DEPTH];
      ref_mix(il, dl, g, e.l, sl);
      ref_mix(ir, dr, g, e.r, sr);
      e.sat = sl | sr;
    end
    mem_l[wp] = e.l;
    mem_r[wp] = e.r;
    wp = (wp + 1) % DEPTH;
    io.LeftRecData  = l;
    io.RightRecData = r;
    io.delay        = AW'(dly);
    io.gain         = GW'(g);
    io.bypass       = byp;
    io.NewFrame     = 1'b1;
    e.cyc = cyc + 7;
    sbq.push_back(e);
    @(negedge audio_clk);
    io.NewFrame     = 1'b0;
    io.LeftRecData  = N'($urandom);
    io.RightRecData = N'($urandom);
    io.delay        = AW'($urandom);
    io.gain         = GW'($urandom);
    io.bypass       = 1'($urandom);
  endtask

  task automatic frame(input logic [N-1:0] l, input logic [N-1:0] r,
                       input int dly, input int g, input bit byp, input int gap);
    launch(l, r, dly, g, byp);
    repeat (7 + gap) @(negedge audio_clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    io.NewFrame = 1'b0; io.LeftRecData = '0; io.RightRecData = '0;
    io.delay = '0; io.gain = '0; io.bypass = 1'b0;
    do_reset(1'b1);
    chk("post_clear_left", io.LeftPlayData, 0);

    // Echo decay of a left impulse
    obs_l.delete(); obs_r.delete(); obs_sat.delete();
    for (int i = 0; i < 11; i++) frame((i == 0) ? 24'h100000 : 24'h0, 24'h0, 4, 128, 1'b0, 0);
    chk("echo_frames", obs_l.size(), 11);
    for (int i = 0; i < 11 && i < obs_l.size(); i++) begin
      int ev;
      ev = (i == 0) ? 32'h100000 : (i == 4) ? 32'h080000 : (i == 8) ? 32'h040000 : 0;
      chk($sformatf("echo_left_f%0d", i), obs_l[i], ev);
      chk($sformatf("echo_right_f%0d", i), obs_r[i], 0);
    end

    // Saturation, positive then negative, then zero gain
    base = obs_l.size();
    repeat (3) frame(24'h7FFFFF, 24'h0, 1, 255, 1'b0, 0);
    repeat (3) frame(24'h800000, 24'h0, 1, 255, 1'b0, 0);
    frame(24'h3A5A5A, 24'hC00001, 1, 0, 1'b0, 0);
    chk("sat_pos_val",  obs_l[base+1], MAXP);
    chk("sat_pos_flag", obs_sat[base+1], 1);
    chk("sat_neg_val",  obs_l[base+4], MINN);
    chk("sat_neg_flag", obs_sat[base+4], 1);
    chk("gain0_left",   obs_l[base+6], 32'h3A5A5A);
    chk("gain0_sat",    obs_sat[base+6], 0);

    // Bypass and zero delay
    base = obs_l.size();
    frame(24'h123456, 24'hFEDCBA, 3, 200, 1'b1, 1);
    frame(24'h2468AC, 24'hF00F00, 0, 255, 1'b0, 2);
    chk("bypass_left",  obs_l[base],   32'h123456);
    chk("bypass_right", obs_r[base],   int'($signed(24'hFEDCBA)));
    chk("bypass_sat",   obs_sat[base], 0);
    chk("dly0_left",    obs_l[base+1], 32'h2468AC);
    chk("dly0_right",   obs_r[base+1], int'($signed(24'hF00F00)));

    // Randomized frames, some near full scale
    for (int i = 0; i < 60; i++) begin
      logic [N-1:0] l, r;
      l = N'($urandom);
      r = N'($urandom);
      if ($urandom_range(0, 2) == 0) r = {r[N-1], {(N-1){~r[N-1]}}};
      frame(l, r, $urandom_range(0, 8), $urandom_range(0, 255),
            ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
    end

    // Maximum delay across the write-pointer wrap
    @(negedge audio_clk);
    do_reset(1'b0);
    obs_l.delete(); obs_r.delete(); obs_sat.delete();
    for (int i = 0; i < 1030; i++) frame((i == 2) ? 24'h100000 : 24'h0, 24'h0, 1023, 128, 1'b0, 0);
    chk("wrap_frames",  obs_l.size(), 1030);
    chk("wrap_impulse", obs_l[2], 32'h100000);
    chk("wrap_echo",    obs_l[1025], 32'h080000);
    chk("wrap_quiet",   obs_l[1024] | obs_l[1026] | obs_l[1029], 0);

    // Back-to-back rises: second is dropped
    do_reset(1'b0);
    chk("b2b_overrun_before", io.overrun, 0);
    launch(24'h0ABCDE, 24'hF54321, 2, 100, 1'b0);
    repeat (2) @(negedge audio_clk);
    io.LeftRecData = 24'h7FFFFF;
    io.NewFrame    = 1'b1;
    @(negedge audio_clk);
    io.NewFrame    = 1'b0;
    repeat (8) @(negedge audio_clk);
    chk("b2b_overrun", io.overrun, 1);
    chk("b2b_left",    int'($signed(io.LeftPlayData)), 32'h0ABCDE);

    // Reset during MIX_R abandons the frame
    frame(24'h111111, 24'h222222, 0, 0, 1'b0, 0);
    launch(24'h333333, 24'h444444, 1, 128, 1'b0);
    repeat (4) @(negedge audio_clk);
    do_reset(1'b0);
    frame(24'h055555, 24'hFAAAAA, 1, 64, 1'b0, 2);

    repeat (20) @(negedge audio_clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
